cpu_sequencer: RTL

Multi-cycle fetch/decode/execute control unit for the 8-bit CPU. It owns the program counter, a 4×8-bit register file and a carry flag. It fetches instructions from `RAM` and sequences operand, load and store accesses. It drives the combinational `ALU` and `Cond` blocks and consumes their results. It sits directly between `RAM` (upstream data source) and `ALU`/`Cond` (downstream executors), replacing the free-running `Counter` as PC source.

---
 rtl/cpu_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Owns pc, a 4x8 register file and the carry flag, and drives RAM, ALU and Cond.
module cpu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ram_value,
  output logic       ram_load,
  output logic       ram_save,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_panic,
  output logic [7:0] cond_a,
  output logic [2:0] cond_op,
  input  logic       cond_out,
  output logic [7:0] pc,
  output logic       carry,
  output logic       halted,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_MEMRD   = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  // Instruction class field ir[6:5] for two-byte instructions.
  localparam logic [1:0] CLS_LDI = 2'b00;
  localparam logic [1:0] CLS_LD  = 2'b01;
  localparam logic [1:0] CLS_ST  = 2'b10;
  localparam logic [1:0] CLS_JMP = 2'b11;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [6:0]  ir_q, ir_d;
  logic [7:0]  regs [4];
  logic        carry_q;

  logic        reg_we;
  logic [1:0]  reg_wa;
  logic [7:0]  reg_wd;
  logic        carry_we;
  logic        carry_d;
  logic        load_c;
  logic        save_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 7'h00;
      carry_q <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (reg_we)   regs[reg_wa] <= reg_wd;
      if (carry_we) carry_q      <= carry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    reg_we   = 1'b0;
    reg_wa   = ir_q[1:0];
    reg_wd   = ram_value;
    carry_we = 1'b0;
    carry_d  = alu_carry;
    load_c   = 1'b0;
    save_c   = 1'b0;
    ram_addr = pc_q;
    ram_data = 8'h00;
    // ALU operands come straight from the instruction byte on the RAM bus.
    alu_op   = ram_value[6:4];
    alu_a    = regs[ram_value[3:2]];
    alu_b    = regs[ram_value[1:0]];
    cond_op  = ir_q[4:2];
    cond_a   = regs[ir_q[1:0]];

    case (state_q)
      S_FETCH: begin
        load_c  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!ram_value[7]) begin
          if (alu_panic) begin
            state_d = S_HALT;
          end else begin
            reg_we   = 1'b1;
            reg_wa   = ram_value[3:2];
            reg_wd   = alu_out;
            carry_we = 1'b1;
            pc_d     = pc_q + 8'd1;
            state_d  = S_FETCH;
          end
        end else begin
          ir_d     = ram_value[6:0];
          load_c   = 1'b1;
          ram_addr = pc_q + 8'd1;
          state_d  = S_OPERAND;
        end
      end
      S_OPERAND: begin
        case (ir_q[6:5])
          CLS_LDI: begin
            reg_we  = 1'b1;
            pc_d    = pc_q + 8'd2;
            state_d = S_FETCH;
          end
          CLS_ST: begin
            save_c   = 1'b1;
            ram_addr = ram_value;
            ram_data = regs[ir_q[1:0]];
            pc_d     = pc_q + 8'd2;
            state_d  = S_FETCH;
          end
          CLS_JMP: begin
            pc_d    = cond_out ? ram_value : pc_q + 8'd2;
            state_d = S_FETCH;
          end
          CLS_LD: begin
            load_c   = 1'b1;
            ram_addr = ram_value;
            state_d  = S_MEMRD;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        reg_we  = 1'b1;
        pc_d    = pc_q + 8'd2;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // RAM strobes are single-cycle commands with no back-pressure; gating them
  // with reset keeps an aborted instruction from touching memory.
  assign ram_load  = load_c & ~reset;
  assign ram_save  = save_c & ~reset;
  assign pc        = pc_q;
  assign carry     = carry_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_state = state_q;

endmodule
